// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the instruction-memory byte-stream loader:
//   FSM state encoding, frame geometry constants, default sizing
//   parameters and the header word-count legality check.
package imem_loader_pkg;

  localparam int unsigned HDR_BYTES     = 2;
  localparam int unsigned WORD_BYTES    = 4;
  localparam int unsigned CNT_W         = 8 * HDR_BYTES;
  localparam int unsigned DEF_ADDR_W    = 12;
  localparam int unsigned DEF_MAX_WORDS = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // A frame must carry at least one word and no more than the memory holds.
  function automatic logic count_legal(input logic [CNT_W-1:0] n,
                                       input int unsigned      max_words);
    return (n != '0) && (32'(n) <= max_words);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler
//   Collects stream bytes MSB-first into 32-bit words.
//   Ports:
//     clk_i          clock
//     reset_i        synchronous active-high reset
//     clear_i        restart assembly at byte 0 (session start)
//     byte_valid_i   a data byte is accepted this cycle
//     byte_i         the accepted byte
//     word_o         assembled word (valid while word_valid_o is high)
//     word_valid_o   pulses on the cycle the 4th byte of a word is accepted
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned BC_W = $clog2(WORD_BYTES);

  logic [BC_W-1:0] bcnt_q, bcnt_d;
  // Only the first three bytes are held; the final byte is taken straight
  // from the input so the word is available on its accept cycle.
  logic [23:0]     shift_q, shift_d;
  logic            last_byte;

  assign last_byte    = (bcnt_q == BC_W'(WORD_BYTES - 1));
  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && last_byte;

  always_comb begin
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      bcnt_d  = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      shift_d = {shift_q[15:0], byte_i};
      bcnt_d  = last_byte ? '0 : bcnt_q + BC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bcnt_q  <= '0;
      shift_q <= '0;
    end else begin
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Program loader upstream of instruction fetch. Accepts a framed byte
//   stream (CNT_HI, CNT_LO, 4*N big-endian data bytes, XOR checksum) over
//   valid/ready, writes words into instruction memory through its init
//   port, and holds the core in reset until a load ends with a good checksum.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     start               one-cycle request to begin a load (IDLE/ERR only)
//     in_data/in_valid    stream byte and its valid
//     in_ready            loader accepts a byte this cycle
//     init_mode           instruction memory in load mode
//     write_enable        one-cycle word write strobe
//     init_address        word index being written
//     init_instruction    word being written
//     core_reset          holds the core in reset
//     busy                session in progress (same as init_mode)
//     done                one-cycle pulse on successful completion
//     error               sticky bad-header / bad-checksum flag
//     words_loaded        write strobes issued in this session
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned MAX_WORDS = DEF_MAX_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              init_mode,
  output logic              write_enable,
  output logic [ADDR_W-1:0] init_address,
  output logic [31:0]       init_instruction,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       instr_q, instr_d;
  logic              we_q, we_d;
  logic              core_reset_q, core_reset_d;
  logic              error_q, error_d;

  logic              accept;
  logic              start_ok;
  logic              last_word;
  logic [CNT_W-1:0]  n_full;
  logic [31:0]       asm_word;
  logic              asm_valid;

  assign in_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                    (state_q == ST_DATA)   || (state_q == ST_CSUM);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_ERR));

  // Full count as it will be once the low header byte lands.
  assign n_full    = {cnt_q[CNT_W-1:8], in_data};
  assign last_word = (32'(widx_q) == (32'(cnt_q) - 32'd1));

  word_assembler u_asm (
    .clk_i        (clk),
    .reset_i      (reset),
    .clear_i      (start_ok),
    .byte_valid_i (accept && (state_q == ST_DATA)),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    widx_d       = widx_q;
    wl_d         = wl_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    we_d         = 1'b0;
    core_reset_d = core_reset_q;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d      = ST_HDR_HI;
          xor_d        = '0;
          widx_d       = '0;
          wl_d         = '0;
          error_d      = 1'b0;
          core_reset_d = 1'b1;
        end
      end
      ST_HDR_HI: begin
        if (accept) begin
          cnt_d   = {in_data, cnt_q[7:0]};
          xor_d   = xor_q ^ in_data;
          state_d = ST_HDR_LO;
        end
      end
      ST_HDR_LO: begin
        if (accept) begin
          cnt_d = n_full;
          xor_d = xor_q ^ in_data;
          if (count_legal(n_full, MAX_WORDS)) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (asm_valid) begin
            addr_d  = widx_q;
            instr_d = asm_word;
            we_d    = 1'b1;
            wl_d    = wl_q + (ADDR_W+1)'(1);
            widx_d  = widx_q + ADDR_W'(1);
            if (last_word) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
            error_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        core_reset_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      xor_q        <= '0;
      widx_q       <= '0;
      wl_q         <= '0;
      addr_q       <= '0;
      instr_q      <= '0;
      we_q         <= 1'b0;
      core_reset_q <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      widx_q       <= widx_d;
      wl_q         <= wl_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      we_q         <= we_d;
      core_reset_q <= core_reset_d;
      error_q      <= error_d;
    end
  end

  assign init_mode        = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign busy             = init_mode;
  assign done             = (state_q == ST_DONE);
  assign write_enable     = we_q;
  assign init_address     = addr_q;
  assign init_instruction = instr_q;
  assign core_reset       = core_reset_q;
  assign error            = error_q;
  assign words_loaded     = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        init_mode;
  logic        write_enable;
  logic [11:0] init_address;
  logic [31:0] init_instruction;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [12:0] words_loaded;

  imem_loader #(.ADDR_W(12), .MAX_WORDS(4096)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .init_mode        (init_mode),
    .write_enable     (write_enable),
    .init_address     (init_address),
    .init_instruction (init_instruction),
    .core_reset       (core_reset),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .words_loaded     (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write/done monitor, sampled on the falling edge.
  logic [11:0] wa [0:63];
  logic [31:0] wd [0:63];
  int          wr_total   = 0;
  int          done_total = 0;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      if (wr_total < 64) begin
        wa[wr_total] <= init_address;
        wd[wr_total] <= init_instruction;
      end
      wr_total <= wr_total + 1;
    end
    if (done === 1'b1) done_total <= done_total + 1;
  end

  logic [7:0] frame [0:10];
  int         gtab  [0:7];
  int         wr_base;
  int         done_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
  endtask

  task automatic send_seq(input int first, input int last, input bit use_gaps);
    for (int i = first; i <= last; i++)
      send_byte(frame[i], use_gaps ? gtab[i % 8] : 0);
  endtask

  // Sends the 10 header/data bytes, checks the last strobe lands on the
  // first CSUM cycle, then sends the given checksum byte.
  task automatic send_frame(input logic [7:0] csum, input bit use_gaps);
    wr_base   = wr_total;
    done_base = done_total;
    send_seq(0, 9, use_gaps);
    @(negedge clk);
    in_valid = 1'b0;
    chk("last_we", {63'd0, write_enable}, 64'd1);
    chk("last_addr", {52'd0, init_address}, 64'd1);
    chk("last_wl", {51'd0, words_loaded}, 64'd2);
    chk("csum_ready", {63'd0, in_ready}, 64'd1);
    send_byte(csum, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_good_result(input string tag);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_crst_done"}, {63'd0, core_reset}, 64'd1);
    @(negedge clk);
    chk({tag, "_mode_idle"}, {63'd0, init_mode}, 64'd0);
    chk({tag, "_crst_rel"}, {63'd0, core_reset}, 64'd0);
    chk({tag, "_nwr"}, 64'(wr_total - wr_base), 64'd2);
    chk({tag, "_a0"}, {52'd0, wa[wr_base]}, 64'd0);
    chk({tag, "_d0"}, {32'd0, wd[wr_base]}, 64'h20080005);
    chk({tag, "_a1"}, {52'd0, wa[wr_base+1]}, 64'd1);
    chk({tag, "_d1"}, {32'd0, wd[wr_base+1]}, 64'h00000000);
    chk({tag, "_ndone"}, 64'(done_total - done_base), 64'd1);
    chk({tag, "_wl"}, {51'd0, words_loaded}, 64'd2);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_mode"}, {63'd0, init_mode}, 64'd0);
    chk({tag, "_we"}, {63'd0, write_enable}, 64'd0);
    chk({tag, "_addr"}, {52'd0, init_address}, 64'd0);
    chk({tag, "_instr"}, {32'd0, init_instruction}, 64'd0);
    chk({tag, "_crst"}, {63'd0, core_reset}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, error}, 64'd0);
    chk({tag, "_wl"}, {51'd0, words_loaded}, 64'd0);
  endtask

  initial begin
    frame[0] = 8'h00; frame[1] = 8'h02;
    frame[2] = 8'h20; frame[3] = 8'h08; frame[4] = 8'h00; frame[5] = 8'h05;
    frame[6] = 8'h00; frame[7] = 8'h00; frame[8] = 8'h00; frame[9] = 8'h00;
    frame[10] = 8'h2F;
    gtab[0] = 1; gtab[1] = 0; gtab[2] = 3; gtab[3] = 0;
    gtab[4] = 2; gtab[5] = 1; gtab[6] = 0; gtab[7] = 2;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");

    // Good load, no gaps.
    pulse_start();
    chk("start_mode", {63'd0, init_mode}, 64'd1);
    chk("start_ready", {63'd0, in_ready}, 64'd1);
    send_frame(8'h2F, 1'b0);
    check_good_result("good");

    // Bad checksum.
    pulse_start();
    send_frame(8'h2E, 1'b0);
    chk("badcs_err", {63'd0, error}, 64'd1);
    chk("badcs_mode", {63'd0, init_mode}, 64'd0);
    chk("badcs_ready", {63'd0, in_ready}, 64'd0);
    chk("badcs_crst", {63'd0, core_reset}, 64'd1);
    chk("badcs_nwr", 64'(wr_total - wr_base), 64'd2);
    chk("badcs_nodone", 64'(done_total - done_base), 64'd0);
    @(negedge clk);
    chk("badcs_err_sticky", {63'd0, error}, 64'd1);
    chk("badcs_crst_hold", {63'd0, core_reset}, 64'd1);

    // Illegal count 0, started from ERR.
    pulse_start();
    chk("restart_err_clr", {63'd0, error}, 64'd0);
    wr_base = wr_total;
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("cnt0_err", {63'd0, error}, 64'd1);
    chk("cnt0_ready", {63'd0, in_ready}, 64'd0);
    chk("cnt0_mode", {63'd0, init_mode}, 64'd0);
    @(negedge clk);
    chk("cnt0_nwr", 64'(wr_total - wr_base), 64'd0);
    chk("cnt0_wl", {51'd0, words_loaded}, 64'd0);

    // Illegal count 4097.
    pulse_start();
    wr_base = wr_total;
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("cnt4097_err", {63'd0, error}, 64'd1);
    chk("cnt4097_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    chk("cnt4097_nwr", 64'(wr_total - wr_base), 64'd0);

    // Good load from ERR with in_valid gaps.
    pulse_start();
    chk("gap_err_clr", {63'd0, error}, 64'd0);
    send_frame(8'h2F, 1'b1);
    check_good_result("gap");

    // Reset after 6 data bytes, then a fresh good load.
    pulse_start();
    send_seq(0, 7, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    check_reset_values("midrst");
    pulse_start();
    send_frame(8'h2F, 1'b0);
    check_good_result("afterrst");

    // start during DATA is ignored; session completes.
    pulse_start();
    wr_base   = wr_total;
    done_base = done_total;
    send_seq(0, 3, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    chk("busy_start_mode", {63'd0, init_mode}, 64'd1);
    send_seq(4, 9, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_start_we", {63'd0, write_enable}, 64'd1);
    send_byte(8'h2F, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check_good_result("busystart");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader placed directly upstream of the instruction fetch stage. It accepts a framed byte stream (header, big-endian instruction words, XOR checksum) over a valid/ready handshake. It drives the instruction memory init interface (`init_mode`, `write_enable`, `init_address`, `init_instruction`). It holds the core in reset until a load completes with a correct checksum.

## Interface

**Parameters**
- `ADDR_W`, default 12: instruction memory word-address width.
- `MAX_WORDS`, default 4096: largest legal word count; must be ≤ 2^ADDR_W.

**Ports**
- `clk`  in  1  — single clock; all logic on its rising edge.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — one-cycle request to begin a load session.
- `in_data`  in  8  — stream byte.
- `in_valid`  in  1  — `in_data` is valid.
- `in_ready`  out  1  — loader accepts a byte this cycle.
- `init_mode`  out  1  — instruction memory in load mode.
- `write_enable`  out  1  — one-cycle word write strobe.
- `init_address`  out  ADDR_W  — word index to write.
- `init_instruction`  out  32  — word to write.
- `core_reset`  out  1  — holds the processor core in reset.
- `busy`  out  1  — session in progress.
- `done`  out  1  — one-cycle pulse on successful completion.
- `error`  out  1  — sticky; set by a bad header or bad checksum.
- `words_loaded`  out  ADDR_W+1  — write strobes issued in the current session.

## Operation

- **Frame format:** `CNT_HI`, `CNT_LO` (16-bit word count N), then 4·N data bytes (MSB first per word), then 1 checksum byte.
- **Checksum rule:** XOR of every header and data byte equals the checksum byte.
- **Byte acceptance:** a byte is accepted when `in_valid & in_ready`.
- **States:**
  - IDLE → HDR_HI on `start`.
  - HDR_HI → HDR_LO on byte accept.
  - HDR_LO → DATA on byte accept if 1 ≤ N ≤ `MAX_WORDS`; otherwise → ERR.
  - DATA → CSUM on the 4th byte of word N−1.
  - CSUM → DONE on byte accept when the checksum matches; otherwise → ERR.
  - DONE → IDLE unconditionally.
  - ERR → HDR_HI on `start`.
- **`in_ready`:** high exactly in HDR_HI, HDR_LO, DATA and CSUM.
- **Word assembly:** a 32-bit shift register, byte counter 0..3, and a running XOR.
- **Word write:** on the 4th byte of a word, register `init_instruction` and `init_address` = word index, and pulse `write_enable`. Word index starts at 0 and increments after each strobe.
- **`init_mode`:** high in every state except IDLE and ERR.
- **`busy`:** equals `init_mode`.
- **`core_reset`:**
  - Reset value 1.
  - Cleared only on the cycle DONE → IDLE.
  - Set again on any `start`.
  - Stays 1 in ERR.
- **`error`:** set on entry to ERR; cleared on `start`.
- **Start cleanup:** `start` clears `words_loaded`, the word index, the byte counter and the XOR.
- **Ignored `start`:** `start` in HDR_HI/HDR_LO/DATA/CSUM/DONE has no effect.
- **Reset (including mid-load) forces:** IDLE, `in_ready`=0, `init_mode`=0, `write_enable`=0, `init_address`=0, `init_instruction`=0, `core_reset`=1, `busy`=0, `done`=0, `error`=0, `words_loaded`=0.
- **Partial loads:** words already written before an error remain in memory. No rollback.

## Timing

- `start` at cycle t → HDR_HI, with `init_mode`=1 and `in_ready`=1 at t+1.
- Throughput: one byte per cycle sustained; `in_valid` gaps stall without loss.
- Write latency: `write_enable` is high the cycle after the 4th byte of a word is accepted, with `init_address`/`init_instruction` valid in that same cycle. Strobes are at least 4 cycles apart.
- Last-word overlap: the last write strobe coincides with the first CSUM cycle.
- Completion: checksum accepted at cycle c → `done`=1 at c+1 (DONE). At c+2 (IDLE): `init_mode`=0 and `core_reset`=0.
- Error timing: a bad header or checksum accepted at cycle c → `error`=1, `init_mode`=0 at c+1.
- `words_loaded` increments in the same cycle as `write_enable`.

## Structure

- **Package `imem_loader_pkg`:**
  - state enum (IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR);
  - `HDR_BYTES`=2, `WORD_BYTES`=4;
  - default `ADDR_W`/`MAX_WORDS`.
- **Sub-module `word_assembler`:** byte counter, 32-bit MSB-first shift register, and a `word_valid` pulse on the 4th byte. The top level holds the FSM, count compare, XOR, address counter and outputs.

## Test plan

- **Good load:** bytes 00 02 20 08 00 05 00 00 00 00 2F.
  - Two strobes: addr 0 = 0x20080005, addr 1 = 0x00000000.
  - `done` pulse, then `core_reset` 1→0; `words_loaded`=2; `error`=0.
- **Bad checksum:** same frame with final byte 0x2E.
  - Both strobes still occur.
  - `error`=1, `done` never pulses, `core_reset` stays 1, `init_mode`=0.
- **Illegal count:** header 00 00, and separately header 10 01 (4097).
  - ERR entered after `CNT_LO`; no `write_enable`; `in_ready`=0 afterwards.
- **Backpressure/gaps:** good frame with `in_valid` toggling randomly.
  - Identical writes and result to the good-load case; no byte lost or duplicated.
- **Reset mid-load:** `reset` asserted after 6 data bytes.
  - Next cycle: all outputs at reset values, `core_reset`=1.
  - A fresh `start` plus a good frame then loads correctly from addr 0.
- **Restart after error and `start` while busy:**
  - `start` during DATA: ignored; the session completes normally.
  - `start` in ERR: clears `error`; a new good frame succeeds.
